segre_cache_ctrl: RTL and testbench
===================================

SEGRE_CACHE_CTRL -- requirements
Module: segre_cache_ctrl

Interface
REQ-001 SHALL have: clk_i  input  1  single clock, all state on rising edge.
REQ-002 SHALL have: rsn_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: req_valid_i  input  1  pipeline access request, held stable until rsp_valid_o.
REQ-004 SHALL have: req_wr_i  input  1  1 = store, 0 = load.
REQ-005 SHALL have: req_addr_i  input  WORD_SIZE  access byte address.
REQ-006 SHALL have: req_ready_o  output  1  controller in IDLE.
REQ-007 SHALL have: rsp_valid_o  output  1  access completes this cycle (hit).
REQ-008 SHALL have: tag_addr_o  output  WORD_SIZE  address driven to the tag array.
REQ-009 SHALL have: tag_is_hit_i  input  1  tag compare result from the tag array.
REQ-010 SHALL have: tag_in_index_i  input  TAG_SIZE  stored tag at the indexed line.
REQ-011 SHALL have: tag_wr_en_o  output  1  tag array write enable.
REQ-012 SHALL have: data_wr_en_o  output  1  store-hit write into the data array.
REQ-013 SHALL have: data_fill_en_o  output  1  refill line write into the data array.
REQ-014 SHALL have: mem_rd_req_o, mem_wr_req_o  output  1 each  memory line read/write request.
REQ-015 SHALL have: mem_addr_o  output  WORD_SIZE  line-aligned memory address (bits M-1:0 = 0).
REQ-016 SHALL have: mem_ack_i  input  1  one-cycle memory completion pulse.
REQ-017 SHALL have: hit_cnt_o, miss_cnt_o  output  32 each  saturating access counters.

Function
REQ-018 SHALL hold per-line valid[NUMBER_OF_LINES] and dirty[NUMBER_OF_LINES] bits internally; hit = tag_is_hit_i AND valid[index], index = addr[N-1:M].
REQ-019 SHALL implement FSM states IDLE, WRITEBACK, REFILL; req_ready_o = 1 only in IDLE.
REQ-020 SHALL drive tag_addr_o = req_addr_i in IDLE, latched miss address otherwise.
REQ-021 IDLE, req_valid_i and hit: rsp_valid_o = 1 combinationally same cycle (zero-cycle latency); if req_wr_i, data_wr_en_o = 1 and dirty[index] set at next edge; hit_cnt_o increments.
REQ-022 IDLE, req_valid_i and miss: latch req_addr_i, increment miss_cnt_o, next state WRITEBACK if valid[index] AND dirty[index], else REFILL; rsp_valid_o = 0.
REQ-023 WRITEBACK: mem_wr_req_o = 1, mem_addr_o = {tag_in_index_i, index, M'b0}; remain until mem_ack_i, then REFILL.
REQ-024 REFILL: mem_rd_req_o = 1, mem_addr_o = {latched tag, index, M'b0}; on mem_ack_i assert data_fill_en_o and tag_wr_en_o that cycle, set valid[index], clear dirty[index], go IDLE.
REQ-025 After REFILL the held request SHALL replay in IDLE and hit (write-allocate for stores); each miss costs one extra miss-count only, the replay counts as a hit.
REQ-026 mem_ack_i in IDLE SHALL be ignored; mem_rd_req_o and mem_wr_req_o SHALL never be high together.
REQ-027 Counters SHALL saturate at 32'hFFFF_FFFF.
REQ-028 tag_wr_en_o, data_fill_en_o, data_wr_en_o SHALL be 0 in every case not listed above.

Reset
REQ-029 rsn_i low SHALL asynchronously force state IDLE, valid/dirty all 0, counters 0, latched address 0.
REQ-030 During reset all request/enable outputs SHALL be 0, req_ready_o = 1, mem_addr_o = 0; reset mid-WRITEBACK/REFILL SHALL abandon the transfer with no tag/data write.

Structure
REQ-031 segre_pkg SHALL hold cache_state_e (IDLE, WRITEBACK, REFILL) plus existing WORD_SIZE, N, M, NUMBER_OF_LINES, TAG_SIZE.
REQ-032 No sub-module; segre_cache_ctrl SHALL be instantiated beside segre_cache_tags inside the cache top, wiring tag_addr_o/tag_wr_en_o to it.

Verification
REQ-033 After reset, load 0x0000_0040 -> miss, REFILL with mem_addr_o 0x40, ack, replay hits: rsp_valid_o 1, hit_cnt 1, miss_cnt 1.
REQ-034 Store hit at 0x40 -> data_wr_en_o 1 same cycle, dirty set; load to conflicting address (same index, different tag) -> WRITEBACK to 0x40 then REFILL new address.
REQ-035 Load miss to clean conflicting line -> direct IDLE->REFILL, mem_wr_req_o never asserted.
REQ-036 rsn_i low during REFILL with mem_ack_i pending -> IDLE, tag_wr_en_o 0, previously valid line reads as miss.
REQ-037 Force hit_cnt to 32'hFFFF_FFFF, issue hit -> stays FFFF_FFFF; stray mem_ack_i in IDLE -> no state change.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared cache parameters and controller state encoding.
// Line size 2^M bytes, NUMBER_OF_LINES direct-mapped lines.
package segre_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int M               = 4;
  localparam int N               = 8;
  localparam int INDEX_SIZE      = N - M;
  localparam int NUMBER_OF_LINES = 1 << INDEX_SIZE;
  localparam int TAG_SIZE        = WORD_SIZE - N;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } cache_state_e;

endpackage

// File: rtl/segre_cache_ctrl.sv
// Direct-mapped write-back cache controller.
// Zero-latency hits in IDLE; misses write back dirty victim then refill.
module segre_cache_ctrl
  import segre_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 req_valid_i,
  input  logic                 req_wr_i,
  input  logic [WORD_SIZE-1:0] req_addr_i,
  output logic                 req_ready_o,
  output logic                 rsp_valid_o,
  output logic [WORD_SIZE-1:0] tag_addr_o,
  input  logic                 tag_is_hit_i,
  input  logic [TAG_SIZE-1:0]  tag_in_index_i,
  output logic                 tag_wr_en_o,
  output logic                 data_wr_en_o,
  output logic                 data_fill_en_o,
  output logic                 mem_rd_req_o,
  output logic                 mem_wr_req_o,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  input  logic                 mem_ack_i,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  cache_state_e state_q, state_d;

  logic [WORD_SIZE-1:0]       addr_q, addr_d;
  logic [NUMBER_OF_LINES-1:0] valid_q, valid_d;
  logic [NUMBER_OF_LINES-1:0] dirty_q, dirty_d;
  logic [31:0]                hit_cnt_q, hit_cnt_d;
  logic [31:0]                miss_cnt_q, miss_cnt_d;

  logic [WORD_SIZE-1:0]  cur_addr;
  logic [INDEX_SIZE-1:0] idx;
  logic                  hit;
  logic                  hit_inc;
  logic                  miss_inc;

  // Address presented to the tags: live request in IDLE, held miss otherwise.
  always_comb begin
    cur_addr = (state_q == IDLE) ? req_addr_i : addr_q;
    idx      = cur_addr[N-1:M];
    hit      = tag_is_hit_i & valid_q[idx];
  end

  assign tag_addr_o = cur_addr;
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  // Next-state, handshake, memory and array-enable decode.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    req_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    tag_wr_en_o    = 1'b0;
    data_wr_en_o   = 1'b0;
    data_fill_en_o = 1'b0;
    mem_rd_req_o   = 1'b0;
    mem_wr_req_o   = 1'b0;
    mem_addr_o     = '0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (hit) begin
            rsp_valid_o  = 1'b1;
            hit_inc      = 1'b1;
            data_wr_en_o = req_wr_i;
            if (req_wr_i) dirty_d[idx] = 1'b1;
          end else begin
            miss_inc = 1'b1;
            addr_d   = req_addr_i;
            if (valid_q[idx] && dirty_q[idx])
              state_d = WRITEBACK;
            else
              state_d = REFILL;
          end
        end
      end
      WRITEBACK: begin
        mem_wr_req_o = 1'b1;
        mem_addr_o   = {tag_in_index_i, idx, {M{1'b0}}};
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        mem_rd_req_o = 1'b1;
        mem_addr_o   = {addr_q[WORD_SIZE-1:N], idx, {M{1'b0}}};
        if (mem_ack_i) begin
          data_fill_en_o = 1'b1;
          tag_wr_en_o    = 1'b1;
          valid_d[idx]   = 1'b1;
          dirty_d[idx]   = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating hit/miss counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && hit_cnt_q != 32'hFFFF_FFFF)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (miss_inc && miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // State, held miss address, line status and counters.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_segre_cache_ctrl.sv
// Directed bench for segre_cache_ctrl.
// Behavioural tag array, hand-computed expectations.
module tb_segre_cache_ctrl;
  import segre_pkg::*;

  logic                 clk;
  logic                 rsn;
  logic                 req_valid;
  logic                 req_wr;
  logic [WORD_SIZE-1:0] req_addr;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [WORD_SIZE-1:0] tag_addr;
  logic                 tag_is_hit;
  logic [TAG_SIZE-1:0]  tag_in_index;
  logic                 tag_wr_en;
  logic                 data_wr_en;
  logic                 data_fill_en;
  logic                 mem_rd_req;
  logic                 mem_wr_req;
  logic [WORD_SIZE-1:0] mem_addr;
  logic                 mem_ack;
  logic [31:0]          hit_cnt;
  logic [31:0]          miss_cnt;

  int n_chk;
  int n_fail;
  int n_overlap;

  logic [TAG_SIZE-1:0] tags [NUMBER_OF_LINES] = '{default: '0};

  segre_cache_ctrl dut (
    .clk_i          (clk),
    .rsn_i          (rsn),
    .req_valid_i    (req_valid),
    .req_wr_i       (req_wr),
    .req_addr_i     (req_addr),
    .req_ready_o    (req_ready),
    .rsp_valid_o    (rsp_valid),
    .tag_addr_o     (tag_addr),
    .tag_is_hit_i   (tag_is_hit),
    .tag_in_index_i (tag_in_index),
    .tag_wr_en_o    (tag_wr_en),
    .data_wr_en_o   (data_wr_en),
    .data_fill_en_o (data_fill_en),
    .mem_rd_req_o   (mem_rd_req),
    .mem_wr_req_o   (mem_wr_req),
    .mem_addr_o     (mem_addr),
    .mem_ack_i      (mem_ack),
    .hit_cnt_o      (hit_cnt),
    .miss_cnt_o     (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tag_in_index = tags[tag_addr[N-1:M]];
  assign tag_is_hit   = (tag_in_index == tag_addr[WORD_SIZE-1:N]);

  always @(posedge clk)
    if (tag_wr_en)
      tags[tag_addr[N-1:M]] <= tag_addr[WORD_SIZE-1:N];

  always @(negedge clk)
    if (mem_rd_req && mem_wr_req)
      n_overlap <= n_overlap + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
  endtask

  task automatic ack_fill();
    mem_ack = 1'b1;
    #1;
    chk("fill_en", {31'd0, data_fill_en}, 32'd1);
    chk("tag_wr", {31'd0, tag_wr_en}, 32'd1);
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    n_overlap = 0;
    rsn       = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    mem_ack   = 1'b0;

    // reset state
    #2;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mem", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_hits", hit_cnt, 32'd0);
    chk("rst_miss", miss_cnt, 32'd0);
    tick();
    tick();
    rsn = 1'b1;
    tick();

    // cold load miss at 0x40, refill, replay hit
    issue(1'b0, 32'h0000_0040);
    @(negedge clk);
    chk("t1_rsp0", {31'd0, rsp_valid}, 32'd0);
    chk("t1_ready", {31'd0, req_ready}, 32'd1);
    tick();
    @(negedge clk);
    chk("t1_rd", {31'd0, mem_rd_req}, 32'd1);
    chk("t1_wr", {31'd0, mem_wr_req}, 32'd0);
    chk("t1_maddr", mem_addr, 32'h40);
    chk("t1_busy", {31'd0, req_ready}, 32'd0);
    chk("t1_miss", miss_cnt, 32'd1);
    ack_fill();
    @(negedge clk);
    chk("t1_replay", {31'd0, rsp_valid}, 32'd1);
    chk("t1_dwr", {31'd0, data_wr_en}, 32'd0);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t1_hits", hit_cnt, 32'd1);
    chk("t1_miss2", miss_cnt, 32'd1);

    // store hit marks line dirty
    tick();
    issue(1'b1, 32'h0000_0044);
    @(negedge clk);
    chk("t2_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("t2_dwr", {31'd0, data_wr_en}, 32'd1);
    tick();
    req_valid = 1'b0;

    // conflicting load: writeback 0x40 then refill 0x140
    issue(1'b0, 32'h0000_0140);
    @(negedge clk);
    chk("t3_rsp0", {31'd0, rsp_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("t3_wb", {31'd0, mem_wr_req}, 32'd1);
    chk("t3_wb_rd", {31'd0, mem_rd_req}, 32'd0);
    chk("t3_wbaddr", mem_addr, 32'h40);
    mem_ack = 1'b1;
    #1;
    chk("t3_wb_tagwr", {31'd0, tag_wr_en}, 32'd0);
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("t3_rf", {31'd0, mem_rd_req}, 32'd1);
    chk("t3_rf_wr", {31'd0, mem_wr_req}, 32'd0);
    chk("t3_rfaddr", mem_addr, 32'h140);
    ack_fill();
    @(negedge clk);
    chk("t3_replay", {31'd0, rsp_valid}, 32'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t3_hits", hit_cnt, 32'd3);
    chk("t3_miss", miss_cnt, 32'd2);

    // clean conflict goes straight to refill
    issue(1'b0, 32'h0000_0248);
    tick();
    @(negedge clk);
    chk("t4_rd", {31'd0, mem_rd_req}, 32'd1);
    chk("t4_nowb", {31'd0, mem_wr_req}, 32'd0);
    chk("t4_maddr", mem_addr, 32'h240);
    ack_fill();
    @(negedge clk);
    chk("t4_replay", {31'd0, rsp_valid}, 32'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t4_hits", hit_cnt, 32'd4);
    chk("t4_miss", miss_cnt, 32'd3);

    // reset during refill with ack pending
    issue(1'b0, 32'h0000_0340);
    tick();
    @(negedge clk);
    chk("t5_rf", {31'd0, mem_rd_req}, 32'd1);
    mem_ack = 1'b1;
    rsn     = 1'b0;
    #1;
    chk("t5_tagwr", {31'd0, tag_wr_en}, 32'd0);
    chk("t5_fill", {31'd0, data_fill_en}, 32'd0);
    chk("t5_ready", {31'd0, req_ready}, 32'd1);
    chk("t5_maddr", mem_addr, 32'h0);
    chk("t5_rd0", {31'd0, mem_rd_req}, 32'd0);
    tick();
    rsn       = 1'b1;
    mem_ack   = 1'b0;
    req_valid = 1'b0;
    chk("t5_hits", hit_cnt, 32'd0);
    issue(1'b0, 32'h0000_0240);
    @(negedge clk);
    chk("t5_miss_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("t5_miss", miss_cnt, 32'd1);
    chk("t5_rfaddr", mem_addr, 32'h240);
    ack_fill();
    tick();
    req_valid = 1'b0;

    // stray ack in IDLE
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("t6_ready", {31'd0, req_ready}, 32'd1);
    chk("t6_rd", {31'd0, mem_rd_req}, 32'd0);
    chk("t6_hits", hit_cnt, 32'd1);
    chk("t6_miss", miss_cnt, 32'd1);

    // hit counter saturation
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.hit_cnt_q;
    tick();
    issue(1'b0, 32'h0000_0240);
    @(negedge clk);
    chk("t7_rsp", {31'd0, rsp_valid}, 32'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t7_sat", hit_cnt, 32'hFFFF_FFFF);
    chk("t7_miss", miss_cnt, 32'd1);

    chk("rdwr_overlap", n_overlap, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
